// File: rtl/refill_pkg.sv
// refill_pkg: shared types and line geometry for the line-refill sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package refill_pkg;

  // Line geometry: 16 words of 4 bytes form one 64-byte line
  localparam int WORDS_PER_LINE = 16;
  localparam int WORD_BYTE_BITS = 2;
  localparam int OFFSET_BITS    = 6;
  localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
  localparam int DATA_W         = 32;

  // Refill sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } refill_state_t;

  // Which cache owns the refill in progress
  localparam logic OWNER_ICACHE = 1'b0;
  localparam logic OWNER_DCACHE = 1'b1;

  // Index of the final beat of a line
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  // Word index of a beat: offset from the start word, wrapping within the line
  function automatic logic [BEAT_W-1:0] beat_word_index(
    input logic [BEAT_W-1:0] start_word,
    input logic [BEAT_W-1:0] beat_count
  );
    return start_word + beat_count;
  endfunction

endpackage

// File: rtl/refill_rr_arbiter.sv
// refill_rr_arbiter: two-way round-robin grant between I-cache and D-cache refill requests.
// Latency: grant is combinational from the requests; lastGrant updates on the advance strobe.
// Backpressure: none here; a losing requester simply keeps its request up until served.
module refill_rr_arbiter
  import refill_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_reqIcache,
  input  logic i_reqDcache,
  input  logic i_advance,
  input  logic i_advanceOwner,
  output logic o_grantValid,
  output logic o_grantOwner
);

  // Owner of the most recently completed refill
  logic r_lastGrant;

  // Grant: lone requester wins; on a tie the side that was not served last wins
  always_comb begin
    o_grantValid = i_reqIcache | i_reqDcache;
    o_grantOwner = OWNER_ICACHE;
    if (i_reqIcache && i_reqDcache) begin
      o_grantOwner = ~r_lastGrant;
    end else if (i_reqDcache) begin
      o_grantOwner = OWNER_DCACHE;
    end
  end

  // History: starts at D-cache so the first tie goes to the I-cache
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_lastGrant <= OWNER_DCACHE;
    end else if (i_advance) begin
      r_lastGrant <= i_advanceOwner;
    end
  end

endmodule

// File: rtl/refill_arbiter.sv
// refill_arbiter: shares one memory read port between I-cache and D-cache 64-byte line refills.
// Latency: memRequest one cycle after grant; 2 cycles/beat at zero-wait memory; FillDone 33 cycles after request.
// Backpressure: memRequest/memAddress held stable until memReady; one beat outstanding; other cache waits.
// Option: define REFILL_CRITICAL_WORD_FIRST_EN to start each burst at the missing word and wrap.
module refill_arbiter
  import refill_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_icacheMissRequest,
  input  logic [ADDR_WIDTH-1:0] i_icacheMissAddress,
  input  logic                  i_dcacheMissRequest,
  input  logic [ADDR_WIDTH-1:0] i_dcacheMissAddress,
  output logic                  o_icacheFillValid,
  output logic                  o_dcacheFillValid,
  output logic [BEAT_W-1:0]     o_fillWordIndex,
  output logic [DATA_W-1:0]     o_fillData,
  output logic                  o_icacheFillDone,
  output logic                  o_dcacheFillDone,
  output logic                  o_memRequest,
  output logic [ADDR_WIDTH-1:0] o_memAddress,
  input  logic                  i_memReady,
  input  logic                  i_memReadValid,
  input  logic [DATA_W-1:0]     i_memReadData,
  output logic                  o_busy
);

  // FSM state
  refill_state_t r_state;
  refill_state_t w_nextState;

  // Refill context latched at grant
  logic                             r_owner;
  logic [ADDR_WIDTH-1:OFFSET_BITS]  r_lineBase;
  logic [BEAT_W-1:0]                r_startWord;
  logic [BEAT_W-1:0]                r_beatCount;

  // Registered fill beat presented to the caches
  logic                             r_fillValid;
  logic [DATA_W-1:0]                r_fillData;
  logic [BEAT_W-1:0]                r_fillWordIndex;

  // Arbiter interface
  logic                             w_grantValid;
  logic                             w_grantOwner;
  logic                             w_advance;

  // Datapath helpers
  logic [ADDR_WIDTH-1:0]            w_reqAddr;
  logic [BEAT_W-1:0]                w_startWord;
  logic [BEAT_W-1:0]                w_wordIndex;
  logic                             w_grantTake;
  logic                             w_beatReturn;
  logic                             w_lastBeat;
  logic                             w_unusedAddrBits;

  // The completed refill's owner becomes the round-robin history at DONE
  assign w_advance = (r_state == ST_DONE);

  refill_rr_arbiter u_rr (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_reqIcache    (i_icacheMissRequest),
    .i_reqDcache    (i_dcacheMissRequest),
    .i_advance      (w_advance),
    .i_advanceOwner (r_owner),
    .o_grantValid   (w_grantValid),
    .o_grantOwner   (w_grantOwner)
  );

  // Miss address of whichever cache is being granted
  assign w_reqAddr = (w_grantOwner == OWNER_DCACHE) ? i_dcacheMissAddress : i_icacheMissAddress;

  // Byte offset bits only matter for the start word, and only when critical-word-first is on
  assign w_unusedAddrBits = ^w_reqAddr[OFFSET_BITS-1:0];

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  // Critical word first: begin at the missing word, later beats wrap around the line
  assign w_startWord = w_reqAddr[OFFSET_BITS-1:WORD_BYTE_BITS];
`else
  // Linear fill: always begin at word 0
  assign w_startWord = '0;
`endif

  assign w_wordIndex  = beat_word_index(r_startWord, r_beatCount);
  assign w_grantTake  = (r_state == ST_IDLE) && w_grantValid;
  assign w_beatReturn = (r_state == ST_WAIT) && i_memReadValid;
  assign w_lastBeat   = (r_beatCount == LAST_BEAT);

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: one request/response pair per beat, DONE always returns to IDLE
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grantValid) begin
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_memReady) begin
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_memReadValid) begin
          w_nextState = w_lastBeat ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Outputs: request/address only in ISSUE, fill strobes steered to the owner
  always_comb begin
    o_memRequest      = 1'b0;
    o_memAddress      = '0;
    o_icacheFillDone  = 1'b0;
    o_dcacheFillDone  = 1'b0;
    o_icacheFillValid = r_fillValid && (r_owner == OWNER_ICACHE);
    o_dcacheFillValid = r_fillValid && (r_owner == OWNER_DCACHE);
    o_busy            = (r_state != ST_IDLE);
    case (r_state)
      ST_ISSUE: begin
        o_memRequest = 1'b1;
        o_memAddress = {r_lineBase, w_wordIndex, {WORD_BYTE_BITS{1'b0}}};
      end
      ST_DONE: begin
        o_icacheFillDone = (r_owner == OWNER_ICACHE);
        o_dcacheFillDone = (r_owner == OWNER_DCACHE);
      end
      default: begin
      end
    endcase
  end

  assign o_fillData      = r_fillData;
  assign o_fillWordIndex = r_fillWordIndex;

  // Refill context: captured at grant, beat counter advances on each returned word
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_owner     <= OWNER_ICACHE;
      r_lineBase  <= '0;
      r_startWord <= '0;
      r_beatCount <= '0;
    end else if (w_grantTake) begin
      r_owner     <= w_grantOwner;
      r_lineBase  <= w_reqAddr[ADDR_WIDTH-1:OFFSET_BITS];
      r_startWord <= w_startWord;
      r_beatCount <= '0;
    end else if (w_beatReturn) begin
      r_beatCount <= r_beatCount + 1'b1;
    end
  end

  // Fill beat register: valid pulses one cycle per returned word, data/index hold afterwards
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_fillValid     <= 1'b0;
      r_fillData      <= '0;
      r_fillWordIndex <= '0;
    end else begin
      r_fillValid <= w_beatReturn;
      if (w_beatReturn) begin
        r_fillData      <= i_memReadData;
        r_fillWordIndex <= w_wordIndex;
      end
    end
  end

endmodule

// File: tb/tb_refill_arbiter.sv
// tb_refill_arbiter: scoreboard bench for refill_arbiter with a behavioural memory and cache drivers.
// Latency: checks exact FillDone cycle on zero-wait and stalled refills.
// Backpressure: memory can stall memReady and inject stray memReadValid.
`timescale 1ns/1ps
module tb_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq, dreq;
  logic [31:0] iaddr, daddr;
  logic        ifv, dfv, idone, ddone, mreq, busy;
  logic [3:0]  fidx;
  logic [31:0] fdat, maddr;
  logic        mready, mrvalid;
  logic [31:0] mrdata;

  always #5 clk = ~clk;

  refill_arbiter dut (
    .i_clock             (clk),
    .i_reset             (rst_n),
    .i_icacheMissRequest (ireq),
    .i_icacheMissAddress (iaddr),
    .i_dcacheMissRequest (dreq),
    .i_dcacheMissAddress (daddr),
    .o_icacheFillValid   (ifv),
    .o_dcacheFillValid   (dfv),
    .o_fillWordIndex     (fidx),
    .o_fillData          (fdat),
    .o_icacheFillDone    (idone),
    .o_dcacheFillDone    (ddone),
    .o_memRequest        (mreq),
    .o_memAddress        (maddr),
    .i_memReady          (mready),
    .i_memReadValid      (mrvalid),
    .i_memReadData       (mrdata),
    .o_busy              (busy)
  );

  typedef struct packed {
    logic        own;
    logic [3:0]  idx;
    logic [31:0] dat;
  } fill_t;

  typedef struct {
    logic       own;
    logic [3:0] idx;
    int         cyc;
  } done_t;

  logic [31:0] exp_addr_q[$];
  fill_t       exp_fill_q[$];
  done_t       exp_done_q[$];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int fills_seen = 0;
  int dones_seen = 0;
  int exp_fill_total = 0;
  int exp_dones = 0;
  int stim_timeouts = 0;
  int i_issued = 0, i_served = 0, d_issued = 0, d_served = 0;
  int stall_target = 0, stall_used = 0;
  bit spurious_en = 1'b0;
  bit sim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory model and cache request drivers ----------------
  initial begin : driver
    bit          pend;
    logic [31:0] pend_addr;
    pend = 1'b0; pend_addr = '0;
    ireq = 1'b0; dreq = 1'b0; mready = 1'b0; mrvalid = 1'b0; mrdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; mready = 1'b0; mrvalid = 1'b0; mrdata = '0;
        i_served = i_issued; d_served = d_issued;
      end else begin
        if (idone) i_served++;
        if (ddone) d_served++;
        if (pend) begin
          mrvalid = 1'b1; mrdata = memword(pend_addr); pend = 1'b0;
        end else begin
          mrvalid = spurious_en; mrdata = 32'hBAD0_BAD0;
        end
        if (mreq) begin
          if (stall_used < stall_target) begin
            mready = 1'b0; stall_used++;
          end else begin
            mready = 1'b1; pend = 1'b1; pend_addr = maddr;
          end
        end else begin
          mready = 1'b0;
        end
      end
      ireq = (i_issued != i_served);
      dreq = (d_issued != d_served);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] got);
    tests++; fails++;
    $display("FAIL %s: got 0x%0h, expected no event (cycle %0d)", nm, got, cyc);
  endtask

  initial begin : monitor
    bit          prev_rst;
    bit          held;
    logic [31:0] held_addr;
    prev_rst = 1'b1; held = 1'b0; held_addr = '0;
    while (!sim_done) begin
      @(negedge clk); #1;
      if (!prev_rst) begin
        chk("rst_ctrl", 64'({busy, mreq, ifv, dfv, idone, ddone}), 64'(0));
        chk("rst_addr", 64'(maddr), 64'(0));
        chk("rst_data", 64'({fidx, fdat}), 64'(0));
      end
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_req_held", 64'(mreq), 64'(1));
          chk("stall_addr_held", 64'(maddr), 64'(held_addr));
        end
        held = mreq && !mready;
        held_addr = maddr;
        if (mreq && mready) begin
          if (exp_addr_q.size() == 0) unexpected("unexpected_mem_req", 64'(maddr));
          else chk("mem_addr", 64'(maddr), 64'(exp_addr_q.pop_front()));
        end
        if (ifv && dfv) begin
          unexpected("both_fill_valid", 64'({ifv, dfv}));
        end else if (ifv || dfv) begin
          fills_seen++;
          if (exp_fill_q.size() == 0) begin
            unexpected("unexpected_fill", 64'({dfv, fidx}));
          end else begin
            fill_t e;
            e = exp_fill_q.pop_front();
            chk("fill_owner", 64'(dfv), 64'(e.own));
            chk("fill_idx", 64'(fidx), 64'(e.idx));
            chk("fill_data", 64'(fdat), 64'(e.dat));
          end
        end
        if (idone || ddone) begin
          dones_seen++;
          if (exp_done_q.size() == 0) begin
            unexpected("unexpected_done", 64'({idone, ddone}));
          end else begin
            done_t d;
            d = exp_done_q.pop_front();
            chk("done_owner", 64'({idone, ddone}), d.own ? 64'(1) : 64'(2));
            chk("done_with_last_valid", 64'(d.own ? dfv : ifv), 64'(1));
            chk("done_idx", 64'(fidx), 64'(d.idx));
            if (d.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(d.cyc));
          end
        end
      end
      prev_rst = rst_n;
    end
    chk("stim_timeouts", 64'(stim_timeouts), 64'(0));
    chk("fill_total", 64'(fills_seen), 64'(exp_fill_total));
    chk("addr_q_empty", 64'(exp_addr_q.size()), 64'(0));
    chk("done_q_empty", 64'(exp_done_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic expect_line(input logic own, input logic [31:0] addr, input int done_cyc);
    logic [31:0] base, a;
    logic [3:0]  start, idx;
    done_t       d;
    base = {addr[31:6], 6'b0};
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    start = addr[5:2];
`else
    start = 4'd0;
`endif
    for (int b = 0; b < 16; b++) begin
      idx = start + 4'(b);
      a = base | {26'd0, idx, 2'b00};
      exp_addr_q.push_back(a);
      exp_fill_q.push_back('{own: own, idx: idx, dat: memword(a)});
    end
    d.own = own;
    d.idx = start + 4'd15;
    d.cyc = done_cyc;
    exp_done_q.push_back(d);
    exp_fill_total += 16;
    exp_dones++;
  endtask

  task automatic wait_dones();
    for (int k = 0; k < 400 && dones_seen < exp_dones; k++) step();
    if (dones_seen < exp_dones) begin
      stim_timeouts++;
      $display("FAIL wait_done: got %0d done pulses, expected %0d", dones_seen, exp_dones);
    end
    step(); step();
  endtask

  task automatic wait_fills(input int target);
    for (int k = 0; k < 400 && fills_seen < target; k++) step();
    if (fills_seen < target) begin
      stim_timeouts++;
      $display("FAIL wait_fill: got %0d fills, expected %0d", fills_seen, target);
    end
  endtask

  initial begin : stimulus
    int base_fills;
    rst_n = 1'b0; iaddr = '0; daddr = '0;
    step(); step(); step();
    rst_n = 1'b1;
    step();

    // I-cache alone, miss 0x48, zero-wait memory
    iaddr = 32'h0000_0048;
    expect_line(1'b0, iaddr, cyc + 33);
    i_issued++;
    wait_dones();

    // Stray memReadValid while idle must not produce a fill
    spurious_en = 1'b1;
    step(); step(); step(); step();
    spurious_en = 1'b0;
    step();

    // Both request as reset is released: I first, then D right after I's FillDone
    rst_n = 1'b0;
    step(); step();
    iaddr = 32'h0000_1104; daddr = 32'h0000_2208;
    expect_line(1'b0, iaddr, cyc + 33);
    expect_line(1'b1, daddr, cyc + 67);
    i_issued++; d_issued++;
    rst_n = 1'b1;
    wait_dones();

    // Tie again with D served last: I wins
    iaddr = 32'h0000_4440; daddr = 32'h0000_5580;
    expect_line(1'b0, iaddr, cyc + 33);
    expect_line(1'b1, daddr, cyc + 67);
    i_issued++; d_issued++;
    wait_dones();

    // memReady low for 3 cycles in ISSUE plus stray memReadValid while stalled
    base_fills = fills_seen;
    iaddr = 32'h1000_0084;
    expect_line(1'b0, iaddr, cyc + 36);
    i_issued++;
    wait_fills(base_fills + 5);
    stall_target += 3;
    spurious_en = 1'b1;
    step(); step(); step(); step();
    spurious_en = 1'b0;
    wait_dones();

    // Tie with I served last: D wins
    iaddr = 32'h0000_8B00; daddr = 32'h0000_7A00;
    expect_line(1'b1, daddr, cyc + 33);
    expect_line(1'b0, iaddr, cyc + 67);
    i_issued++; d_issued++;
    wait_dones();

    // Reset after 7 beats: refill abandoned, no FillDone
    base_fills = fills_seen;
    iaddr = 32'h0000_3000;
    expect_line(1'b0, iaddr, -1);
    i_issued++;
    wait_fills(base_fills + 7);
    rst_n = 1'b0;
    step(); step();
    exp_fill_total -= exp_fill_q.size();
    exp_dones -= exp_done_q.size();
    exp_addr_q.delete();
    exp_fill_q.delete();
    exp_done_q.delete();
    rst_n = 1'b1;
    step();

    // Fresh request after reset starts at its first beat
    daddr = 32'h2000_0010;
    expect_line(1'b1, daddr, cyc + 33);
    d_issued++;
    wait_dones();

    // Miss at 0x3C: wraps from word 15 with critical-word-first, linear otherwise
    iaddr = 32'h0000_003C;
    expect_line(1'b0, iaddr, cyc + 33);
    i_issued++;
    wait_dones();

    step(); step(); step();
    sim_done = 1'b1;
  end

endmodule
